// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, drives a stalling instruction memory and feeds
// the IF/ID latch. Handles decode stalls, branch/jump squashes and HALT.
module fetch_stage #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = 16'h0800
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pc_redirect_in,
  input  logic [15:0] pc_target_in,
  input  logic        hazard_stall_in,
  input  logic        halt_in,
  input  logic [15:0] imem_data,
  input  logic        imem_done,
  input  logic        imem_stall,
  output logic [15:0] imem_addr,
  output logic        imem_rd,
  output logic [15:0] instruction_out,
  output logic [15:0] PC_Out,
  output logic        fetch_valid,
  output logic        BranchingOrJumping_out,
  output logic        instructionMemoryStall,
  output logic        latch_en
);

  typedef enum logic [2:0] {
    S_REQ, S_WAIT, S_HOLD, S_DISCARD, S_HALT
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] buf_q, buf_d;
  logic [15:0] addr_q, addr_d;
  logic        halt_pend_q, halt_pend_d;
  logic [15:0] pc_plus2;
  logic [15:0] word;
  logic        present_valid;
  logic        rd;
  logic        flush;
  logic        mstall;

  // Completion is signalled by imem_done alone; the busy flag carries no extra information.
  logic unused_imem_stall;
  assign unused_imem_stall = imem_stall;

  assign pc_plus2 = pc_q + 16'd2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_REQ;
      pc_q        <= RESET_PC;
      buf_q       <= NOP_INSTR;
      addr_q      <= RESET_PC;
      halt_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      buf_q       <= buf_d;
      addr_q      <= addr_d;
      halt_pend_q <= halt_pend_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    buf_d       = buf_q;
    addr_d      = addr_q;
    halt_pend_d = halt_pend_q;
    case (state_q)
      S_REQ, S_WAIT: begin
        // addr_q remembers the in-flight address once the PC has moved to the new path.
        if (pc_redirect_in) begin
          pc_d        = pc_target_in;
          addr_d      = pc_q;
          halt_pend_d = 1'b0;
          state_d     = imem_done ? S_REQ : S_DISCARD;
        end else if (halt_in) begin
          addr_d      = pc_q;
          halt_pend_d = ~imem_done;
          state_d     = imem_done ? S_HALT : S_DISCARD;
        end else if (imem_done) begin
          if (hazard_stall_in) begin
            buf_d   = imem_data;
            state_d = S_HOLD;
          end else begin
            pc_d    = pc_plus2;
            state_d = S_REQ;
          end
        end else begin
          state_d = S_WAIT;
        end
      end
      S_HOLD: begin
        if (pc_redirect_in) begin
          pc_d    = pc_target_in;
          state_d = S_REQ;
        end else if (halt_in) begin
          state_d = S_HALT;
        end else if (!hazard_stall_in) begin
          pc_d    = pc_plus2;
          state_d = S_REQ;
        end
      end
      S_DISCARD: begin
        if (pc_redirect_in) begin
          pc_d        = pc_target_in;
          halt_pend_d = 1'b0;
          if (imem_done) state_d = S_REQ;
        end else if (halt_in) begin
          halt_pend_d = 1'b1;
          if (imem_done) state_d = S_HALT;
        end else if (imem_done) begin
          state_d = halt_pend_q ? S_HALT : S_REQ;
        end
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_REQ;
    endcase
  end

  always_comb begin
    word          = imem_data;
    present_valid = 1'b0;
    rd            = 1'b0;
    imem_addr     = pc_q;
    flush         = 1'b0;
    mstall        = 1'b0;
    case (state_q)
      S_REQ, S_WAIT: begin
        rd            = 1'b1;
        mstall        = ~imem_done;
        present_valid = imem_done & ~hazard_stall_in & ~pc_redirect_in & ~halt_in;
      end
      S_HOLD: begin
        word          = buf_q;
        present_valid = ~hazard_stall_in & ~pc_redirect_in & ~halt_in;
      end
      S_DISCARD: begin
        rd        = 1'b1;
        imem_addr = addr_q;
        flush     = 1'b1;
        mstall    = 1'b1;
      end
      default: ;
    endcase
    if (pc_redirect_in && state_q != S_HALT) flush = 1'b1;
    // Reset must silence the memory and the latch combinationally, not a cycle later.
    if (rst) begin
      rd            = 1'b0;
      present_valid = 1'b0;
      flush         = 1'b0;
    end
  end

  assign imem_rd                = rd;
  assign fetch_valid            = present_valid;
  assign instruction_out        = present_valid ? word : NOP_INSTR;
  assign PC_Out                 = pc_plus2;
  assign BranchingOrJumping_out = flush;
  assign instructionMemoryStall = mstall;
  assign latch_en               = ~hazard_stall_in | pc_redirect_in;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a small memory stand-in answers reads, and a scoreboard
// queue holds the instruction/PC pairs expected at the IF/ID interface.
module tb_fetch_stage;

  localparam logic [15:0] NOP = 16'h0800;

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        pc_redirect_in = 1'b0;
  logic [15:0] pc_target_in = 16'h0000;
  logic        hazard_stall_in = 1'b0;
  logic        halt_in = 1'b0;
  logic [15:0] imem_data = 16'h0000;
  logic        imem_done = 1'b0;
  logic        imem_stall = 1'b0;
  logic [15:0] imem_addr;
  logic        imem_rd;
  logic [15:0] instruction_out;
  logic [15:0] PC_Out;
  logic        fetch_valid;
  logic        BranchingOrJumping_out;
  logic        instructionMemoryStall;
  logic        latch_en;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  fetch_stage dut (
    .clk                    (clk),
    .rst                    (rst),
    .pc_redirect_in         (pc_redirect_in),
    .pc_target_in           (pc_target_in),
    .hazard_stall_in        (hazard_stall_in),
    .halt_in                (halt_in),
    .imem_data              (imem_data),
    .imem_done              (imem_done),
    .imem_stall             (imem_stall),
    .imem_addr              (imem_addr),
    .imem_rd                (imem_rd),
    .instruction_out        (instruction_out),
    .PC_Out                 (PC_Out),
    .fetch_valid            (fetch_valid),
    .BranchingOrJumping_out (BranchingOrJumping_out),
    .instructionMemoryStall (instructionMemoryStall),
    .latch_en               (latch_en)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] memWord(input logic [15:0] a);
    return a ^ 16'h5A31;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [15:0] instr, input logic [15:0] pc);
    exp_t e;
    e.instr = instr;
    e.pc    = pc;
    sb.push_back(e);
  endtask

  // Inputs change on the falling edge; outputs are sampled 1ns later, well clear of posedge.
  task automatic applyStimulus(input logic redir, input logic [15:0] tgt, input logic haz,
                               input logic halt, input logic done, input logic [15:0] data);
    @(negedge clk);
    rst             = 1'b0;
    pc_redirect_in  = redir;
    pc_target_in    = tgt;
    hazard_stall_in = haz;
    halt_in         = halt;
    imem_done       = done;
    imem_stall      = ~done;
    imem_data       = data;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic e_rd, input logic [15:0] e_addr,
                             input logic e_valid, input logic e_flush, input logic e_mstall);
    exp_t e;
    chk({tag, ".rd"}, {15'd0, imem_rd}, {15'd0, e_rd});
    if (e_rd) chk({tag, ".addr"}, imem_addr, e_addr);
    chk({tag, ".valid"}, {15'd0, fetch_valid}, {15'd0, e_valid});
    chk({tag, ".flush"}, {15'd0, BranchingOrJumping_out}, {15'd0, e_flush});
    chk({tag, ".mstall"}, {15'd0, instructionMemoryStall}, {15'd0, e_mstall});
    chk({tag, ".latch_en"}, {15'd0, latch_en}, {15'd0, (~hazard_stall_in | pc_redirect_in)});
    if (fetch_valid) begin
      if (sb.size() == 0) begin
        chk({tag, ".sb_empty"}, 16'd1, 16'd0);
      end else begin
        e = sb.pop_front();
        chk({tag, ".instr"}, instruction_out, e.instr);
        chk({tag, ".pc_out"}, PC_Out, e.pc);
      end
    end else begin
      chk({tag, ".nop"}, instruction_out, NOP);
    end
  endtask

  initial begin
    logic [15:0] a;
    #1 rst = 1'b1;
    @(negedge clk); #1;
    chk("rst.rd", {15'd0, imem_rd}, 16'd0);
    chk("rst.valid", {15'd0, fetch_valid}, 16'd0);
    chk("rst.flush", {15'd0, BranchingOrJumping_out}, 16'd0);
    chk("rst.instr", instruction_out, NOP);
    chk("rst.pc_out", PC_Out, 16'h0002);

    // Back-to-back single-cycle reads.
    for (int k = 0; k < 4; k++) begin
      a = 16'(2 * k);
      push(memWord(a), a + 16'd2);
      applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 1'b1, memWord(a));
      checkOutput($sformatf("t1.%0d", k), 1'b1, a, 1'b1, 1'b0, 1'b0);
    end

    // Slow memory at PC 8: request held with stable address.
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0);
      checkOutput($sformatf("t2.wait%0d", k), 1'b1, 16'h0008, 1'b0, 1'b0, 1'b1);
    end
    push(memWord(16'h0008), 16'h000A);
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 1'b1, memWord(16'h0008));
    checkOutput("t2.done", 1'b1, 16'h0008, 1'b1, 1'b0, 1'b0);

    // Decode stall as word at PC 10 returns: captured once, re-presented later.
    applyStimulus(1'b0, 16'h0, 1'b1, 1'b0, 1'b1, memWord(16'h000A));
    checkOutput("t3.cap", 1'b1, 16'h000A, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 16'hDEAD);
    checkOutput("t3.hold", 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    push(memWord(16'h000A), 16'h000C);
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 16'hBEEF);
    checkOutput("t3.rel", 1'b0, 16'h0, 1'b1, 1'b0, 1'b0);

    // Redirect to 0x40 while read of 12 is pending.
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0);
    checkOutput("t4.req", 1'b1, 16'h000C, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 16'h0040, 1'b0, 1'b0, 1'b0, 16'h0);
    checkOutput("t4.redir", 1'b1, 16'h000C, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0);
    checkOutput("t4.disc", 1'b1, 16'h000C, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 1'b1, memWord(16'h000C));
    checkOutput("t4.drop", 1'b1, 16'h000C, 1'b0, 1'b1, 1'b1);
    push(memWord(16'h0040), 16'h0042);
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 1'b1, memWord(16'h0040));
    checkOutput("t4.new", 1'b1, 16'h0040, 1'b1, 1'b0, 1'b0);

    // Redirect coincident with a decode stall: redirect wins.
    applyStimulus(1'b1, 16'hFFFE, 1'b1, 1'b0, 1'b1, memWord(16'h0042));
    checkOutput("rdhaz", 1'b1, 16'h0042, 1'b0, 1'b1, 1'b0);

    // PC wrap, then HALT with a read outstanding.
    push(memWord(16'hFFFE), 16'h0000);
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 1'b1, memWord(16'hFFFE));
    checkOutput("t5.wrap", 1'b1, 16'hFFFE, 1'b1, 1'b0, 1'b0);
    push(memWord(16'h0000), 16'h0002);
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 1'b1, memWord(16'h0000));
    checkOutput("t5.zero", 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 16'h0);
    checkOutput("t5.haltpend", 1'b1, 16'h0002, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 1'b1, memWord(16'h0002));
    checkOutput("t5.drain", 1'b1, 16'h0002, 1'b0, 1'b1, 1'b1);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(k == 1, 16'h0100, 1'b0, 1'b0, 1'b1, 16'h1234);
      checkOutput($sformatf("t5.halt%0d", k), 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    end

    // Reset exits HALT; then an asynchronous reset in the middle of a WAIT.
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0);
    checkOutput("t6.req", 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0);
    checkOutput("t6.wait", 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("t6.async.rd", {15'd0, imem_rd}, 16'd0);
    chk("t6.async.valid", {15'd0, fetch_valid}, 16'd0);
    chk("t6.async.instr", instruction_out, NOP);
    chk("t6.async.pc_out", PC_Out, 16'h0002);
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0);
    checkOutput("t6.rel", 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1);

    chk("sb.leftover", 16'(sb.size()), 16'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
